// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit: operation
// encodings, default latencies and operation-class helpers.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Operations that occupy the unit for a multi-cycle latency.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_unit_md_calc.sv
// Combinational arithmetic core: produces the full {HI, LO} result for
// mult/multu/div/divu and whether that result may be committed.
module mdu_unit_md_calc
  import mdu_unit_pkg::*;
(
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        write_en
);

  logic        signed_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what keeps a combinational block from inferring a latch.
    result   = 64'd0;
    write_en = 1'b0;

    signed_div = (mdop == MD_DIV);

    // Low 64 bits of the product of sign-extended operands is the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000 as an
    // unsigned magnitude, which makes the -2^31 / -1 overflow fall out naturally.
    div_n = (signed_div && a[31]) ? (~a + 32'd1) : a;
    div_d = (signed_div && b[31]) ? (~b + 32'd1) : b;
    q_u   = (b == 32'd0) ? 32'd0 : (div_n / div_d);
    r_u   = (b == 32'd0) ? 32'd0 : (div_n % div_d);
    q     = (signed_div && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
    r     = (signed_div && a[31]) ? (~r_u + 32'd1) : r_u;

    case (mdop)
      MD_MULT: begin
        result   = prod_s;
        write_en = 1'b1;
      end
      MD_MULTU: begin
        result   = prod_u;
        write_en = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result   = {r, q};
        write_en = (b != 32'd0);
      end
      default: begin
        result   = 64'd0;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div into HI/LO,
// mthi/mtlo writes, mfhi/mflo read mux and start/busy for the stall unit.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdout
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_we;
  logic             busy_q;
  logic [63:0]      calc_result;
  logic             calc_we;

  mdu_unit_md_calc u_calc (
    .mdop     (mdop),
    .a        (a),
    .b        (b),
    .result   (calc_result),
    .write_en (calc_we)
  );

  assign start = is_arith_op(mdop) && (state == ST_IDLE);
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    mdout = 32'd0;
    case (mdop)
      MD_MFHI: mdout = hi_q;
      MD_MFLO: mdout = lo_q;
      default: mdout = 32'd0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register in this
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_BUSY;
            busy_q  <= 1'b1;
            cnt     <= is_mult_op(mdop) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            pend_hi <= calc_result[63:32];
            pend_lo <= calc_result[31:0];
            pend_we <= calc_we;
          end else if (mdop == MD_MTHI) begin
            hi_q <= a;
          end else if (mdop == MD_MTLO) begin
            lo_q <= a;
          end
        end
        ST_BUSY: begin
          // New ops, including mthi/mtlo, are ignored until the count expires.
          if (cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            if (pend_we) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
